// File: rtl/cfg_pkg.sv
// Shared definitions for the CLB configuration loader: FSM encodings and
// small elaboration-time helpers used to size counters.
package cfg_pkg;

  // Loader FSM encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_SET   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Number of bitstream words consumed by one column chain.
  // A word never spans two columns, so this is a plain ceiling divide.
  function automatic int words_per_col(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Counter width for a value range 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clb_cfg_loader_if.sv
// Bitstream word stream into the configuration loader (valid/ready).
interface clb_cfg_loader_if #(
  parameter int WORD_W = 32
);

  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  // Word source side
  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  // Loader side
  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/cfg_word_serializer.sv
// Holds one captured bitstream word and walks it LSB first.
// bit_out is the bit currently presented; last_bit flags the top bit.
module cfg_word_serializer import cfg_pkg::*; #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [WORD_W-1:0] word_in,
  output logic              bit_out,
  output logic              last_bit
);

  localparam int IW = cnt_width(WORD_W);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_W - 1);

  logic [WORD_W-1:0] word_reg;
  logic [IW-1:0]     bit_idx_reg;

  // Capture a new word (restarting at bit 0) or step to the next bit
  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg    <= '0;
      bit_idx_reg <= '0;
    end else if (load) begin
      word_reg    <= word_in;
      bit_idx_reg <= '0;
    end else if (advance) begin
      bit_idx_reg <= bit_idx_reg + IW'(1);
    end
  end

  // Current bit and end-of-word flag
  always_comb begin
    bit_out  = word_reg[bit_idx_reg];
    last_bit = (bit_idx_reg == IDX_LAST);
  end

endmodule

// File: rtl/clb_cfg_loader.sv
// Configuration front end for clb_grid. Takes bitstream words and shifts
// them column by column into the grid's per-column chains, then commits
// all columns with a single set_in pulse and reports done.
module clb_cfg_loader import cfg_pkg::*; #(
  parameter int MX        = 3,
  parameter int CHAIN_LEN = 5,
  parameter int WORD_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  clb_cfg_loader_if.slave        cfg,
  output logic [MX-1:0]          cen_in,
  output logic [MX-1:0]          shift_in,
  output logic [MX-1:0]          set_in,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = cnt_width(CHAIN_LEN);
  localparam int XW = cnt_width(MX);
  localparam logic [CW-1:0] CHAIN_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [XW-1:0] COL_LAST   = XW'(MX - 1);

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] chain_cnt_reg, chain_cnt_next;
  logic [XW-1:0] col_idx_reg, col_idx_next;

  logic ser_load;
  logic ser_advance;
  logic ser_bit;
  logic ser_last;
  logic col_end;
  logic col_last;

  // A word is taken only while waiting in LOAD; bits advance once per SHIFT cycle
  always_comb begin
    ser_load    = (state_reg == ST_LOAD) && cfg.cfg_valid;
    ser_advance = (state_reg == ST_SHIFT);
    col_end     = (chain_cnt_reg == CHAIN_LAST);
    col_last    = (col_idx_reg == COL_LAST);
  end

  cfg_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .advance  (ser_advance),
    .word_in  (cfg.cfg_data),
    .bit_out  (ser_bit),
    .last_bit (ser_last)
  );

  // Next-state logic; column end wins over word end so leftover word bits are dropped
  always_comb begin
    state_next     = state_reg;
    chain_cnt_next = chain_cnt_reg;
    col_idx_next   = col_idx_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next     = ST_LOAD;
          chain_cnt_next = '0;
          col_idx_next   = '0;
        end
      end
      ST_LOAD: begin
        if (cfg.cfg_valid) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        chain_cnt_next = chain_cnt_reg + CW'(1);
        if (col_end) begin
          chain_cnt_next = '0;
          if (col_last) begin
            state_next = ST_SET;
          end else begin
            col_idx_next = col_idx_reg + XW'(1);
            state_next   = ST_LOAD;
          end
        end else if (ser_last) begin
          state_next = ST_LOAD;
        end
      end
      ST_SET: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset abandons any load in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      chain_cnt_reg <= '0;
      col_idx_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      chain_cnt_reg <= chain_cnt_next;
      col_idx_reg   <= col_idx_next;
    end
  end

  // Output decode straight from state so every output is 0 in IDLE
  always_comb begin
    cfg.cfg_ready = (state_reg == ST_LOAD);
    cen_in        = '0;
    shift_in      = '0;
    set_in        = '0;
    if (state_reg == ST_SHIFT) begin
      cen_in = MX'(1) << col_idx_reg;
      if (ser_bit) begin
        shift_in = MX'(1) << col_idx_reg;
      end
    end
    if (state_reg == ST_SET) begin
      set_in = '1;
    end
    busy = (state_reg == ST_LOAD) || (state_reg == ST_SHIFT) || (state_reg == ST_SET);
    done = (state_reg == ST_DONE);
  end

endmodule
